mac_sequencer: RTL and testbench



---
 rtl/mac_sequencer_if.sv | 24 ++
 rtl/mac_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mac_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Result handshake bundle between the MAC sequencer and the output buffer writer.
// The sequencer drives valid/data/addr; the writer returns ready.
interface mac_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_data;
    logic [ADDR_W-1:0] res_addr;

    modport master (
        output res_valid,
        output res_data,
        output res_addr,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_addr,
        output res_ready
    );
endinterface

// File: rtl/mac_sequencer.sv
// Convolution MAC control: walks every valid KxK window of the image, drives
// memory addresses and accumulator controls, and hands each result downstream.
module mac_sequencer #(
    parameter int IMG_W   = 4,
    parameter int IMG_H   = 4,
    parameter int K       = 3,
    parameter int ADDR_W  = 8,
    parameter int FADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  img_addr,
    output logic [FADDR_W-1:0] filt_addr,
    output logic               mac_rst_acc,
    output logic               mac_acc_en,
    input  logic [7:0]         mac_out,
    mac_sequencer_if.master    res
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    localparam logic [ADDR_W-1:0]  IMG_W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]  OUT_W_A    = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0]  OUT_W_LAST = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0]  OUT_H_LAST = ADDR_W'(OUT_H - 1);
    localparam logic [FADDR_W-1:0] K_F        = FADDR_W'(K);
    localparam logic [FADDR_W-1:0] K_LAST     = FADDR_W'(K - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        CAPTURE,
        EMIT,
        DONE
    } state_t;

    state_t             state,  state_n;
    logic [ADDR_W-1:0]  row,    row_n;
    logic [ADDR_W-1:0]  col,    col_n;
    logic [FADDR_W-1:0] fr,     fr_n;
    logic [FADDR_W-1:0] fc,     fc_n;
    logic [7:0]         res_data_q, res_data_n;
    logic [ADDR_W-1:0]  res_addr_q, res_addr_n;
    logic               acc_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            fr         <= '0;
            fc         <= '0;
            res_data_q <= '0;
            res_addr_q <= '0;
            acc_en_q   <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            col        <= col_n;
            fr         <= fr_n;
            fc         <= fc_n;
            res_data_q <= res_data_n;
            res_addr_q <= res_addr_n;
            // Memory read data arrives one cycle after the address issue.
            acc_en_q   <= (state == ACCUM);
        end
    end

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        fr_n       = fr;
        fc_n       = fc;
        res_data_n = res_data_q;
        res_addr_n = res_addr_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            CLEAR: begin
                state_n = ACCUM;
                fr_n    = '0;
                fc_n    = '0;
            end
            ACCUM: begin
                if (fc == K_LAST) begin
                    fc_n = '0;
                    if (fr == K_LAST) begin
                        fr_n    = '0;
                        state_n = DRAIN;
                    end else begin
                        fr_n = fr + FADDR_W'(1);
                    end
                end else begin
                    fc_n = fc + FADDR_W'(1);
                end
            end
            DRAIN: begin
                state_n = CAPTURE;
            end
            CAPTURE: begin
                res_data_n = mac_out;
                res_addr_n = row * OUT_W_A + col;
                state_n    = EMIT;
            end
            EMIT: begin
                if (res.res_ready) begin
                    if (row == OUT_H_LAST && col == OUT_W_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = CLEAR;
                        if (col == OUT_W_LAST) begin
                            col_n = '0;
                            row_n = row + ADDR_W'(1);
                        end else begin
                            col_n = col + ADDR_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                row_n   = '0;
                col_n   = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        mac_rst_acc   = (state == CLEAR);
        mac_acc_en    = acc_en_q;
        img_addr      = '0;
        filt_addr     = '0;
        if (state == ACCUM) begin
            img_addr  = (row + ADDR_W'(fr)) * IMG_W_A + col + ADDR_W'(fc);
            filt_addr = fr * K_F + fc;
        end
        res.res_valid = (state == EMIT);
        res.res_data  = res_data_q;
        res.res_addr  = res_addr_q;
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: vector table, directed corner cases,
// and randomized passes against a behavioural convolution model.
module tb_mac_sequencer;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int K     = 3;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic       busy, done, mac_rst_acc, mac_acc_en;
    logic [7:0] img_addr, mac_out;
    logic [3:0] filt_addr;

    mac_sequencer_if #(.ADDR_W(8)) res_if ();

    mac_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(8), .FADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .img_addr(img_addr), .filt_addr(filt_addr),
        .mac_rst_acc(mac_rst_acc), .mac_acc_en(mac_acc_en), .mac_out(mac_out),
        .res(res_if.master)
    );

    // Single-window instance: image the same size as the filter.
    logic       start2, busy2, done2, rst_acc2, acc_en2;
    logic [7:0] img_addr2;
    logic [3:0] filt_addr2;
    mac_sequencer_if #(.ADDR_W(8)) res2_if ();

    mac_sequencer #(.IMG_W(3), .IMG_H(3), .K(3), .ADDR_W(8), .FADDR_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .img_addr(img_addr2), .filt_addr(filt_addr2),
        .mac_rst_acc(rst_acc2), .mac_acc_en(acc_en2), .mac_out(8'h5A),
        .res(res2_if.master)
    );

    // Behavioural MAC environment: sync-read memories feeding an accumulator.
    logic [7:0] img_mem  [256];
    logic [7:0] filt_mem [16];
    logic [7:0] img_q = '0, filt_q = '0, acc = '0;
    logic       use_stub = 1'b0;
    logic [7:0] mac_fixed = '0;

    always @(posedge clk) begin
        img_q  <= img_mem[img_addr];
        filt_q <= filt_mem[filt_addr];
        if (mac_rst_acc)     acc <= '0;
        else if (mac_acc_en) acc <= acc + 8'(img_q * filt_q);
    end
    assign mac_out = use_stub ? acc : mac_fixed;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got no matching event, expected one", name);
    endtask

    // Expected traffic for one pass, derived from the window definition.
    typedef struct { logic [7:0] img; logic [3:0] filt; } iss_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } res_t;
    iss_t exp_iss[$];
    res_t exp_res[$];

    logic       mon_en = 1'b0;
    logic [7:0] prev_img;
    logic [3:0] prev_filt;
    logic       held;
    logic [7:0] held_data, held_addr;
    int         rst_cnt;

    task automatic plan_pass(input int mode, input logic [7:0] fixed);
        int   sum;
        iss_t ie;
        res_t re;
        exp_iss.delete();
        exp_res.delete();
        for (int r = 0; r < OUT_H; r++) begin
            for (int c = 0; c < OUT_W; c++) begin
                sum = 0;
                for (int fr = 0; fr < K; fr++) begin
                    for (int fc = 0; fc < K; fc++) begin
                        ie.img  = 8'((r + fr) * IMG_W + c + fc);
                        ie.filt = 4'(fr * K + fc);
                        exp_iss.push_back(ie);
                        sum += int'(img_mem[ie.img]) * int'(filt_mem[ie.filt]);
                    end
                end
                re.addr = 8'(r * OUT_W + c);
                case (mode)
                    1:       re.data = 8'(sum);
                    2:       re.data = 8'(16 * (r * OUT_W + c + 1));
                    default: re.data = fixed;
                endcase
                exp_res.push_back(re);
            end
        end
        prev_img  = '0;
        prev_filt = '0;
        held      = 1'b0;
        rst_cnt   = 0;
    endtask

    task automatic monitor();
        if (mac_acc_en) begin
            if (exp_iss.size() == 0) fail("iss_extra");
            else begin
                iss_t e = exp_iss.pop_front();
                check("iss_img", 64'(prev_img), 64'(e.img));
                check("iss_filt", 64'(prev_filt), 64'(e.filt));
            end
        end
        prev_img  = img_addr;
        prev_filt = filt_addr;
        if (mac_rst_acc) rst_cnt++;
        if (held && res_if.res_valid) begin
            check("hold_data", 64'(res_if.res_data), 64'(held_data));
            check("hold_addr", 64'(res_if.res_addr), 64'(held_addr));
            check("stall_quiet", 64'({mac_acc_en, mac_rst_acc}), 64'(0));
        end
        held      = res_if.res_valid && !res_if.res_ready;
        held_data = res_if.res_data;
        held_addr = res_if.res_addr;
        if (res_if.res_valid && res_if.res_ready) begin
            if (exp_res.size() == 0) fail("res_extra");
            else begin
                res_t e = exp_res.pop_front();
                check("res_addr", 64'(res_if.res_addr), 64'(e.addr));
                check("res_data", 64'(res_if.res_data), 64'(e.data));
            end
        end
        if (done) begin
            check("done_res_left", 64'(exp_res.size()), 64'(0));
            check("done_iss_left", 64'(exp_iss.size()), 64'(0));
            check("rst_acc_per_win", 64'(rst_cnt), 64'(OUT_W * OUT_H));
        end
    endtask

    task automatic tick();
        if (mon_en) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!done) fail("done_timeout");
    endtask

    function automatic logic [32:0] outs();
        return {busy, done, mac_rst_acc, mac_acc_en, res_if.res_valid,
                img_addr, filt_addr, res_if.res_data, res_if.res_addr};
    endfunction

    typedef struct {
        logic       start, ready;
        logic       busy, rst_acc, acc_en, valid;
        logic [7:0] img;
        logic [3:0] filt;
        logic [7:0] data;
    } vec_t;
    vec_t tbl [15];

    logic [7:0] w01 [9];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, w, stall_left, seen;
        logic stalled;

        // First window from reset with a constant MAC value of 0x3C.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  4'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  4'd0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1,  4'd1, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2,  4'd2, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4,  4'd3, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5,  4'd4, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd6,  4'd5, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd8,  4'd6, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd9,  4'd7, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd10, 4'd8, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  4'd0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  4'd0, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  4'd0, 8'h3C};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  4'd0, 8'h3C};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  4'd0, 8'h3C};
        w01 = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};

        for (int i = 0; i < 256; i++) img_mem[i] = '0;
        for (int i = 0; i < 16; i++)  filt_mem[i] = '0;

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        res_if.res_ready = 1'b0; res2_if.res_ready = 1'b0;
        mac_fixed = 8'h3C;
        @(posedge clk); #1;
        check("reset_outs", 64'(outs()), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("idle_outs", 64'(outs()), 64'(0));

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start;
            res_if.res_ready = tbl[i].ready;
            tick();
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({tbl[i].busy, 1'b0, tbl[i].rst_acc, tbl[i].acc_en, tbl[i].valid,
                       tbl[i].img, tbl[i].filt, tbl[i].data, 8'h00}));
        end

        // Window (0,1) address walk and acc_en lag.
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("w01_img%0d", i), 64'(img_addr), 64'(w01[i]));
            check($sformatf("w01_filt%0d", i), 64'(filt_addr), 64'(i));
            check($sformatf("w01_en%0d", i), 64'(mac_acc_en), 64'(i != 0));
        end
        tick();
        check("w01_drain_en", 64'({mac_acc_en, img_addr}), 64'({1'b1, 8'd0}));
        tick();
        check("w01_capture_en", 64'(mac_acc_en), 64'(0));
        res_if.res_ready = 1'b1;
        run_to_done(200, cyc);
        tick();
        check("pass1_idle", 64'(busy), 64'(0));

        // Full pass timing with start held high throughout.
        mac_fixed = 8'hA5; use_stub = 1'b0;
        plan_pass(0, 8'hA5);
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        run_to_done(1000, cyc);
        check("done_cycle", 64'(cyc + 1), 64'(53));
        tick();
        check("start_in_done_ignored", 64'({busy, done}), 64'(0));
        plan_pass(0, 8'hA5);
        tick();
        check("start_after_done", 64'(busy), 64'(1));

        // Reset during the third ACCUM cycle.
        start = 1'b0;
        tick(); tick(); tick();
        check("pre_reset_img", 64'(img_addr), 64'(2));
        rst = 1'b1;
        #1;
        check("async_reset_outs", 64'(outs()), 64'(0));
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) seen++;
            tick();
        end
        check("no_done_after_reset", 64'(seen), 64'(0));
        start = 1'b1;
        tick();
        check("restart_clear", 64'(mac_rst_acc), 64'(1));
        start = 1'b0;
        tick();
        check("restart_img", 64'({img_addr, filt_addr, mac_acc_en}), 64'(0));
        run_to_done(200, cyc);
        tick();

        // Per-window MAC values with a 10-cycle stall on the first result.
        plan_pass(2, 8'h00);
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0; stall_left = 0; stalled = 1'b0; cyc = 0;
        while (!done && cyc < 1000) begin
            if (mac_rst_acc) begin
                w++;
                mac_fixed = 8'(16 * w);
            end
            if (res_if.res_valid && !stalled) begin
                stalled = 1'b1;
                stall_left = 10;
            end
            res_if.res_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            tick();
            cyc++;
        end
        if (!done) fail("stall_pass_timeout");
        check("stall_pass_cycles", 64'(cyc + 1), 64'(63));
        tick();

        // Randomized passes against the convolution model.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) img_mem[i] = 8'($urandom);
            for (int i = 0; i < 9; i++)  filt_mem[i] = 8'($urandom);
            use_stub = 1'b1;
            plan_pass(1, 8'h00);
            start = 1'b1;
            tick();
            cyc = 0;
            while (!done && cyc < 2000) begin
                start = 1'($urandom_range(0, 1));
                res_if.res_ready = ($urandom_range(0, 99) < 60);
                tick();
                cyc++;
            end
            if (!done) fail("rand_timeout");
            start = 1'b0;
            tick();
        end
        mon_en = 1'b0;

        // Degenerate single-window instance.
        res2_if.res_ready = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0; seen = 0;
        while (!done2 && cyc < 100) begin
            if (res2_if.res_valid) begin
                check("deg_addr", 64'(res2_if.res_addr), 64'(0));
                check("deg_data", 64'(res2_if.res_data), 64'(8'h5A));
                seen++;
            end
            tick();
            cyc++;
        end
        check("deg_done_cycle", 64'(cyc + 1), 64'(14));
        check("deg_results", 64'(seen), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
